// File: rtl/section_min_max.sv
// section_min_max: groups every sample_count accepted samples into a section
// and reports the section minimum and maximum as offset-binary words over a
// valid/ready handshake. The control state is fully implied by {count, o_valid}.
module section_min_max #(
  parameter int unsigned width        = 16,
  parameter int unsigned sample_count = 32,
  parameter bit          signed_input = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [width-1:0] i_value,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [width-1:0] o_min_value,
  output logic [width-1:0] o_max_value
);

  localparam int unsigned CW = $clog2(sample_count);
  localparam logic [CW-1:0] LAST = CW'(sample_count - 1);

  // FILL: no result pending; PEND: result pending, section still filling;
  // STALL: result pending and the next sample would complete another section.
  typedef enum logic [1:0] {
    FILL,
    PEND,
    STALL
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [width-1:0] acc_min;
  logic [width-1:0] acc_max;
  logic [width-1:0] u;
  logic [width-1:0] new_min;
  logic [width-1:0] new_max;
  logic             accept;
  logic             first;
  logic             last;

  // Map the incoming sample onto the unsigned offset-binary scale.
  always_comb begin
    u = i_value;
    if (signed_input) begin
      u[width-1] = ~i_value[width-1];
    end
  end

  // Decode the implied state from registered count/o_valid only, so i_ready
  // has no combinational path from o_ready or i_valid.
  always_comb begin
    state = FILL;
    if (o_valid) begin
      state = (count == LAST) ? STALL : PEND;
    end
  end

  assign i_ready = (state != STALL);
  assign accept  = i_valid && i_ready;
  assign first   = (count == '0);
  assign last    = (count == LAST);

  // Running extremes including the current sample; a section's first sample
  // seeds both accumulators so nothing carries over between sections.
  always_comb begin
    new_min = u;
    new_max = u;
    if (!first) begin
      new_min = (u < acc_min) ? u : acc_min;
      new_max = (u > acc_max) ? u : acc_max;
    end
  end

  // Section counter, accumulators and result registers. A completing accept
  // can never coincide with an output handshake because i_ready is low in
  // STALL, so the o_valid clear and set below never collide.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count       <= '0;
      acc_min     <= '1;
      acc_max     <= '0;
      o_valid     <= 1'b0;
      o_min_value <= '1;
      o_max_value <= '0;
    end else begin
      if (o_valid && o_ready) begin
        o_valid <= 1'b0;
      end
      if (accept) begin
        acc_min <= new_min;
        acc_max <= new_max;
        if (last) begin
          count       <= '0;
          o_valid     <= 1'b1;
          o_min_value <= new_min;
          o_max_value <= new_max;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule
